// File: rtl/dmem_bridge_pkg.sv
// Shared constants, decode targets and 7-segment lookup for the data-side bus bridge.
package dmem_bridge_pkg;

  localparam logic [19:0] IO_PAGE   = 20'hFFFFF;

  localparam logic [11:0] OFF_SEG   = 12'h000;
  localparam logic [11:0] OFF_TIMER = 12'h020;
  localparam logic [11:0] OFF_LED   = 12'h060;
  localparam logic [11:0] OFF_SW    = 12'h070;

  typedef enum logic [2:0] {
    TGT_RAM   = 3'd0,
    TGT_SEG   = 3'd1,
    TGT_TIMER = 3'd2,
    TGT_LED   = 3'd3,
    TGT_SW    = 3'd4,
    TGT_NONE  = 3'd5
  } tgt_e;

  // Cathode pattern {dp,g,f,e,d,c,b,a}, active-low, decimal point always off.
  function automatic logic [7:0] hex7seg(input logic [3:0] nib);
    logic [7:0] cx;
    case (nib)
      4'h0:    cx = 8'hC0;
      4'h1:    cx = 8'hF9;
      4'h2:    cx = 8'hA4;
      4'h3:    cx = 8'hB0;
      4'h4:    cx = 8'h99;
      4'h5:    cx = 8'h92;
      4'h6:    cx = 8'h82;
      4'h7:    cx = 8'hF8;
      4'h8:    cx = 8'h80;
      4'h9:    cx = 8'h90;
      4'hA:    cx = 8'h88;
      4'hB:    cx = 8'h83;
      4'hC:    cx = 8'hC6;
      4'hD:    cx = 8'hA1;
      4'hE:    cx = 8'h86;
      4'hF:    cx = 8'h8E;
      default: cx = 8'hFF;
    endcase
    return cx;
  endfunction

endpackage

// File: rtl/dmem_bus_bridge_seg7_scanner.sv
// Multiplexed 8-digit 7-segment scanner: prescaler, digit index and registered an/cx drive.
module seg7_scanner #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] value_i,
  output logic [7:0]  an_o,
  output logic [7:0]  cx_o
);
  import dmem_bridge_pkg::*;

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    cx_q, cx_d;

  // Outputs follow idx_q one cycle later, so a new SEG nibble shows on the next update.
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      idx_d   = idx_q + 3'd1;
    end else begin
      idx_d   = idx_q;
    end
    an_d = ~(8'd1 << idx_q);
    cx_d = hex7seg(value_i[{idx_q, 2'b00} +: 4]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q <= '0;
      idx_q   <= 3'd0;
      an_q    <= 8'hFE;
      cx_q    <= 8'hC0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      cx_q    <= cx_d;
    end
  end

  assign an_o = an_q;
  assign cx_o = cx_q;

endmodule

// File: rtl/dmem_bus_bridge.sv
// Data-side bus responder: decodes core loads/stores to data RAM or IO registers.
// Define BRIDGE_TIMER_EN to include the free-running 32-bit TIMER at IO offset 0x020.
module dmem_bus_bridge #(
  parameter int DMEM_AW  = 14,
  parameter int SCAN_DIV = 50000,
  parameter int SW_W     = 24
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [31:0]     addr_i,
  input  logic [31:0]     wdata_i,
  input  logic            wen_i,
  output logic [31:0]     rdata_o,
  input  logic [SW_W-1:0] sw_i,
  output logic [SW_W-1:0] led_o,
  output logic [7:0]      seg_an_o,
  output logic [7:0]      seg_cx_o
);
  import dmem_bridge_pkg::*;

  logic [31:0]        mem_q [0:(2**DMEM_AW)-1];
  logic [DMEM_AW-1:0] ram_idx_s;
  logic               ram_we_s;
  tgt_e               tgt_s;

  logic [SW_W-1:0]    led_q, led_d;
  logic [31:0]        seg_q, seg_d;
  logic [SW_W-1:0]    sw_meta_q, sw_sync_q;
`ifdef BRIDGE_TIMER_EN
  logic [31:0]        timer_q, timer_d;
`endif

  assign ram_idx_s = addr_i[DMEM_AW+1:2];

  // Address decode; TIMER only decodes when the timer is built in.
  always_comb begin
    tgt_s = TGT_NONE;
    if (addr_i[31:12] == IO_PAGE) begin
      case (addr_i[11:0])
        OFF_SEG:   tgt_s = TGT_SEG;
`ifdef BRIDGE_TIMER_EN
        OFF_TIMER: tgt_s = TGT_TIMER;
`endif
        OFF_LED:   tgt_s = TGT_LED;
        OFF_SW:    tgt_s = TGT_SW;
        default:   tgt_s = TGT_NONE;
      endcase
    end else begin
      tgt_s = TGT_RAM;
    end
  end

  // Load data mux, combinational from the current address.
  always_comb begin
    rdata_o = 32'd0;
    case (tgt_s)
      TGT_RAM:   rdata_o = mem_q[ram_idx_s];
      TGT_SEG:   rdata_o = seg_q;
`ifdef BRIDGE_TIMER_EN
      TGT_TIMER: rdata_o = timer_q;
`endif
      TGT_LED:   rdata_o = 32'(led_q);
      TGT_SW:    rdata_o = 32'(sw_sync_q);
      default:   rdata_o = 32'd0;
    endcase
  end

  // IO register next-state; a store only lands in the register it decodes to.
  always_comb begin
    led_d    = led_q;
    seg_d    = seg_q;
    ram_we_s = 1'b0;
`ifdef BRIDGE_TIMER_EN
    timer_d  = timer_q + 32'd1;
`endif
    if (wen_i && !rst_i) begin
      case (tgt_s)
        TGT_RAM:   ram_we_s = 1'b1;
        TGT_SEG:   seg_d    = wdata_i;
`ifdef BRIDGE_TIMER_EN
        TGT_TIMER: timer_d  = wdata_i;
`endif
        TGT_LED:   led_d    = wdata_i[SW_W-1:0];
        default:   ram_we_s = 1'b0;
      endcase
    end else begin
      ram_we_s = 1'b0;
    end
  end

  // IO registers and switch synchroniser.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      led_q     <= '0;
      seg_q     <= 32'd0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
`ifdef BRIDGE_TIMER_EN
      timer_q   <= 32'd0;
`endif
    end else begin
      led_q     <= led_d;
      seg_q     <= seg_d;
      sw_meta_q <= sw_i;
      sw_sync_q <= sw_meta_q;
`ifdef BRIDGE_TIMER_EN
      timer_q   <= timer_d;
`endif
    end
  end

  // Data RAM write port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (ram_we_s) begin
      mem_q[ram_idx_s] <= wdata_i;
    end
  end

  assign led_o = led_q;

  seg7_scanner #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .value_i (seg_q),
    .an_o    (seg_an_o),
    .cx_o    (seg_cx_o)
  );

endmodule
